// File: rtl/midi_message_tx.sv
// midi_message_tx: queues note-on/note-off requests and serialises each one as a
// 3-byte MIDI message (status, note, velocity) on an 8N1 line, idle high.
module midi_message_tx #(
  parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
  parameter int unsigned MIDI_BAUD_RATE  = 31250,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] midi_velocity_in,
  input  logic [7:0] midi_received_note_in,
  input  logic       midi_data_ready_in,
  input  logic       midi_status_in,
  input  logic [3:0] midi_channel_in,
  output logic       midi_tx_out,
  output logic       busy_out,
  output logic       fifo_full_out,
  output logic       overflow_out,
  output logic       msg_sent_out
);

  localparam int unsigned BIT_CYCLES = CLOCK_FREQUENCY / MIDI_BAUD_RATE;
  localparam int unsigned PtrW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW       = PtrW + 1;
  localparam int unsigned CycW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned EntryW     = 19;

  localparam logic [CycW-1:0] CycLast = CycW'(BIT_CYCLES - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // FIFO entry layout: {status, channel[3:0], note[6:0], velocity[6:0]}
  logic [EntryW-1:0] fifo_mem [FIFO_DEPTH];
  logic [EntryW-1:0] entry_in;
  logic [EntryW-1:0] head;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;

  state_e          state_q, state_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [6:0]      byte1_q, byte1_d;
  logic [6:0]      byte2_q, byte2_d;
  logic            tx_q, tx_d;
  logic            msg_sent_q, msg_sent_d;
  logic            overflow_q, overflow_d;
  logic            tick;

  // MIDI data bytes are 7-bit; the top bits of note and velocity are dropped.
  logic unused_msbs;
  assign unused_msbs = ^{midi_received_note_in[7], midi_velocity_in[7]};

  assign entry_in = {midi_status_in, midi_channel_in, midi_received_note_in[6:0],
                     midi_velocity_in[6:0]};
  assign head     = fifo_mem[rd_ptr_q];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntFull);
  assign pop        = (state_q == StIdle) && !fifo_empty;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign push       = midi_data_ready_in && (!fifo_full || pop);
  assign overflow_d = midi_data_ready_in && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= entry_in;
    end
  end

  assign tick = (cyc_q == CycLast);

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    byte1_d    = byte1_q;
    byte2_d    = byte2_q;
    tx_d       = tx_q;
    msg_sent_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d    = StStart;
          tx_d       = 1'b0;
          cyc_d      = '0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          shift_d    = {3'b100, head[18], head[17:14]};
          byte1_d    = head[13:7];
          byte2_d    = head[6:0];
        end
      end

      StStart: begin
        if (tick) begin
          cyc_d     = '0;
          state_d   = StData;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end

      StData: begin
        if (tick) begin
          cyc_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end

      StStop: begin
        if (tick) begin
          cyc_d = '0;
          if (byte_idx_q == 2'd2) begin
            state_d    = StIdle;
            msg_sent_d = 1'b1;
          end else begin
            // Next start bit follows the stop bit with no idle gap.
            state_d    = StStart;
            tx_d       = 1'b0;
            bit_idx_d  = '0;
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = (byte_idx_q == 2'd0) ? {1'b0, byte1_q} : {1'b0, byte2_q};
          end
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      cyc_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      byte1_q    <= '0;
      byte2_q    <= '0;
      tx_q       <= 1'b1;
      msg_sent_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      byte1_q    <= byte1_d;
      byte2_q    <= byte2_d;
      tx_q       <= tx_d;
      msg_sent_q <= msg_sent_d;
      overflow_q <= overflow_d;
    end
  end

  assign midi_tx_out   = tx_q;
  assign busy_out      = (state_q != StIdle) || !fifo_empty;
  assign fifo_full_out = fifo_full;
  assign overflow_out  = overflow_q;
  assign msg_sent_out  = msg_sent_q;

endmodule

// File: tb/tb_midi_message_tx.sv
// tb_midi_message_tx: scoreboard bench; expected MIDI bytes are queued as messages are
// driven and compared as the line decoder recovers them.
module tb_midi_message_tx;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [7:0] midi_velocity_in = '0;
  logic [7:0] midi_received_note_in = '0;
  logic       midi_data_ready_in = 1'b0;
  logic       midi_status_in = 1'b0;
  logic [3:0] midi_channel_in = '0;
  logic       midi_tx_out;
  logic       busy_out;
  logic       fifo_full_out;
  logic       overflow_out;
  logic       msg_sent_out;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  midi_message_tx #(
    .CLOCK_FREQUENCY(312_500),
    .MIDI_BAUD_RATE (31250),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .midi_velocity_in     (midi_velocity_in),
    .midi_received_note_in(midi_received_note_in),
    .midi_data_ready_in   (midi_data_ready_in),
    .midi_status_in       (midi_status_in),
    .midi_channel_in      (midi_channel_in),
    .midi_tx_out          (midi_tx_out),
    .busy_out             (busy_out),
    .fifo_full_out        (fifo_full_out),
    .overflow_out         (overflow_out),
    .msg_sent_out         (msg_sent_out)
  );

  // Drive one message for the coming edge; queue its expected bytes if it will be kept.
  task automatic set_msg(input logic st, input logic [3:0] c, input logic [7:0] n,
                         input logic [7:0] v, input bit accept);
    midi_status_in        = st;
    midi_channel_in       = c;
    midi_received_note_in = n;
    midi_velocity_in      = v;
    midi_data_ready_in    = 1'b1;
    if (accept) begin
      exp_q.push_back(st ? (8'h90 | {4'h0, c}) : (8'h80 | {4'h0, c}));
      exp_q.push_back({1'b0, n[6:0]});
      exp_q.push_back({1'b0, v[6:0]});
    end
  endtask

  // Line decoder: finds a start bit, samples mid-bit, returns bytes {b2,b1,b0},
  // framing error count and the cycle (from the first falling edge) of msg_sent_out.
  task automatic recv_msg(input int budget, output int waited, output logic [23:0] bytes,
                          output int ferr, output int sent_at);
    waited  = -1;
    ferr    = 0;
    sent_at = -1;
    bytes   = 'x;
    if (midi_tx_out === 1'b0) begin
      waited = 0;
    end else begin
      for (int i = 1; i <= budget; i++) begin
        @(negedge clk_in);
        if (midi_tx_out === 1'b0) begin
          waited = i;
          break;
        end
      end
    end
    if (waited < 0) return;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) begin
        repeat (5) @(negedge clk_in);
        if (midi_tx_out !== 1'b0) ferr++;
      end
      repeat (5) @(negedge clk_in);
      if (midi_tx_out !== 1'b0) ferr++;
      for (int i = 0; i < 8; i++) begin
        repeat (10) @(negedge clk_in);
        bytes[8*j+i] = midi_tx_out;
      end
      repeat (10) @(negedge clk_in);
      if (midi_tx_out !== 1'b1) ferr++;
    end
    for (int c = 296; c <= 320; c++) begin
      @(negedge clk_in);
      if (msg_sent_out === 1'b1) begin
        sent_at = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2 rst_in = 1'b1;
    #1;
    tests_run += 5;
    if (midi_tx_out !== 1'b1) begin
      tests_failed++; $display("FAIL reset_tx: got %b expected 1", midi_tx_out);
    end
    if (busy_out !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy_out);
    end
    if (fifo_full_out !== 1'b0) begin
      tests_failed++; $display("FAIL reset_full: got %b expected 0", fifo_full_out);
    end
    if (overflow_out !== 1'b0) begin
      tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow_out);
    end
    if (msg_sent_out !== 1'b0) begin
      tests_failed++; $display("FAIL reset_msg_sent: got %b expected 0", msg_sent_out);
    end
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_idle;
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in);
      if (midi_tx_out !== 1'b1 || overflow_out !== 1'b0 || msg_sent_out !== 1'b0 ||
          busy_out !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL idle_line: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_single;
    int waited, ferr, sent_at;
    logic [23:0] bytes;
    logic [7:0] e;
    set_msg(1'b1, 4'd0, 8'd60, 8'd127, 1'b1);
    @(negedge clk_in);
    midi_data_ready_in = 1'b0;
    tests_run += 2;
    if (midi_tx_out !== 1'b1) begin
      tests_failed++; $display("FAIL single_early_tx: got %b expected 1", midi_tx_out);
    end
    if (busy_out !== 1'b1) begin
      tests_failed++; $display("FAIL single_busy: got %b expected 1", busy_out);
    end
    recv_msg(20, waited, bytes, ferr, sent_at);
    tests_run += 3;
    if (waited != 1) begin
      tests_failed++; $display("FAIL single_latency: got %0d expected 1", waited);
    end
    if (ferr != 0) begin
      tests_failed++; $display("FAIL single_framing: got %0d errors expected 0", ferr);
    end
    if (sent_at != 300) begin
      tests_failed++; $display("FAIL single_length: got %0d expected 300", sent_at);
    end
    for (int j = 0; j < 3; j++) begin
      e = 8'hxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      tests_run++;
      if (bytes[8*j+:8] !== e) begin
        tests_failed++; $display("FAIL single_byte%0d: got %h expected %h", j, bytes[8*j+:8], e);
      end
    end
    tests_run++;
    if (busy_out !== 1'b0) begin
      tests_failed++; $display("FAIL single_busy_end: got %b expected 0", busy_out);
    end
    @(negedge clk_in);
    tests_run++;
    if (msg_sent_out !== 1'b0) begin
      tests_failed++; $display("FAIL single_pulse_width: got %b expected 0", msg_sent_out);
    end
  endtask

  task automatic test_note_off;
    int waited, ferr, sent_at;
    logic [23:0] bytes;
    logic [7:0] e;
    set_msg(1'b0, 4'd3, 8'hC5, 8'h80, 1'b1);
    @(negedge clk_in);
    midi_data_ready_in = 1'b0;
    recv_msg(20, waited, bytes, ferr, sent_at);
    tests_run += 2;
    if (ferr != 0 || waited != 1) begin
      tests_failed++; $display("FAIL noteoff_frame: got ferr=%0d wait=%0d expected 0/1", ferr, waited);
    end
    if (sent_at != 300) begin
      tests_failed++; $display("FAIL noteoff_length: got %0d expected 300", sent_at);
    end
    for (int j = 0; j < 3; j++) begin
      e = 8'hxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      tests_run++;
      if (bytes[8*j+:8] !== e) begin
        tests_failed++; $display("FAIL noteoff_byte%0d: got %h expected %h", j, bytes[8*j+:8], e);
      end
    end
  endtask

  task automatic test_patterns;
    int waited, ferr, sent_at;
    logic [23:0] bytes;
    logic [7:0] e;
    for (int m = 0; m < 4; m++) begin
      set_msg(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
              8'($urandom), 1'b1);
      @(negedge clk_in);
      midi_data_ready_in = 1'b0;
      recv_msg(20, waited, bytes, ferr, sent_at);
      tests_run++;
      if (ferr != 0 || sent_at != 300) begin
        tests_failed++; $display("FAIL pattern%0d_frame: got ferr=%0d len=%0d expected 0/300",
                                 m, ferr, sent_at);
      end
      for (int j = 0; j < 3; j++) begin
        e = 8'hxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        tests_run++;
        if (bytes[8*j+:8] !== e) begin
          tests_failed++; $display("FAIL pattern%0d_byte%0d: got %h expected %h",
                                   m, j, bytes[8*j+:8], e);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int lows = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          set_msg(1'(k), 4'(k), 8'(40 + k), 8'(10 * k + 1), k < 5);
          @(negedge clk_in);
          if (k == 4) begin
            tests_run += 2;
            if (fifo_full_out !== 1'b1) begin
              tests_failed++; $display("FAIL burst_full: got %b expected 1", fifo_full_out);
            end
            if (overflow_out !== 1'b0) begin
              tests_failed++; $display("FAIL burst_no_ovf: got %b expected 0", overflow_out);
            end
          end
        end
        midi_data_ready_in = 1'b0;
        tests_run++;
        if (overflow_out !== 1'b1) begin
          tests_failed++; $display("FAIL burst_ovf: got %b expected 1", overflow_out);
        end
        @(negedge clk_in);
        tests_run++;
        if (overflow_out !== 1'b0) begin
          tests_failed++; $display("FAIL burst_ovf_pulse: got %b expected 0", overflow_out);
        end
      end
      begin
        int waited, ferr, sent_at;
        logic [23:0] bytes;
        logic [7:0] e;
        for (int m = 0; m < 5; m++) begin
          recv_msg(20, waited, bytes, ferr, sent_at);
          tests_run += 2;
          if (waited != ((m == 0) ? 2 : 1)) begin
            tests_failed++; $display("FAIL burst%0d_gap: got %0d expected %0d",
                                     m, waited, (m == 0) ? 2 : 1);
          end
          if (ferr != 0 || sent_at != 300) begin
            tests_failed++; $display("FAIL burst%0d_frame: got ferr=%0d len=%0d expected 0/300",
                                     m, ferr, sent_at);
          end
          for (int j = 0; j < 3; j++) begin
            e = 8'hxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            tests_run++;
            if (bytes[8*j+:8] !== e) begin
              tests_failed++; $display("FAIL burst%0d_byte%0d: got %h expected %h",
                                       m, j, bytes[8*j+:8], e);
            end
          end
        end
      end
    join
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_in);
      if (midi_tx_out !== 1'b1) lows++;
    end
    tests_run += 2;
    if (lows != 0) begin
      tests_failed++; $display("FAIL burst_dropped_sent: got %0d low cycles expected 0", lows);
    end
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL burst_queue: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_full_pop;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          set_msg(1'b1, 4'(k + 8), 8'(70 + k), 8'(90 + k), 1'b1);
          @(negedge clk_in);
        end
        midi_data_ready_in = 1'b0;
        tests_run++;
        if (fifo_full_out !== 1'b1) begin
          tests_failed++; $display("FAIL fullpop_full: got %b expected 1", fifo_full_out);
        end
      end
      begin
        int waited, ferr, sent_at;
        logic [23:0] bytes;
        logic [7:0] e;
        for (int m = 0; m < 6; m++) begin
          recv_msg(20, waited, bytes, ferr, sent_at);
          if (m == 0) begin
            // Push lands on the same edge as the pop of the next queued message.
            set_msg(1'b0, 4'd15, 8'd99, 8'd33, 1'b1);
            @(negedge clk_in);
            midi_data_ready_in = 1'b0;
            tests_run += 2;
            if (overflow_out !== 1'b0) begin
              tests_failed++; $display("FAIL fullpop_ovf: got %b expected 0", overflow_out);
            end
            if (fifo_full_out !== 1'b1) begin
              tests_failed++; $display("FAIL fullpop_still_full: got %b expected 1",
                                       fifo_full_out);
            end
          end
          tests_run++;
          if (ferr != 0 || sent_at != 300 || waited < 0) begin
            tests_failed++; $display("FAIL fullpop%0d_frame: got ferr=%0d len=%0d wait=%0d",
                                     m, ferr, sent_at, waited);
          end
          for (int j = 0; j < 3; j++) begin
            e = 8'hxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            tests_run++;
            if (bytes[8*j+:8] !== e) begin
              tests_failed++; $display("FAIL fullpop%0d_byte%0d: got %h expected %h",
                                       m, j, bytes[8*j+:8], e);
            end
          end
        end
      end
    join
  endtask

  task automatic test_reset_mid_frame;
    int waited, ferr, sent_at, bad;
    logic [23:0] bytes;
    logic [7:0] e;
    set_msg(1'b1, 4'd1, 8'd50, 8'd60, 1'b1);
    @(negedge clk_in);
    set_msg(1'b1, 4'd2, 8'd51, 8'd61, 1'b1);
    @(negedge clk_in);
    midi_data_ready_in = 1'b0;
    tests_run++;
    if (midi_tx_out !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_start: got %b expected 0", midi_tx_out);
    end
    repeat (150) @(negedge clk_in);
    rst_in = 1'b1;
    exp_q.delete();
    #1;
    tests_run += 2;
    if (midi_tx_out !== 1'b1) begin
      tests_failed++; $display("FAIL rst_mid_tx: got %b expected 1", midi_tx_out);
    end
    if (busy_out !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_busy: got %b expected 0", busy_out);
    end
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_in);
      if (midi_tx_out !== 1'b1 || msg_sent_out !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", bad);
    end
    set_msg(1'b1, 4'd5, 8'd64, 8'd100, 1'b1);
    @(negedge clk_in);
    midi_data_ready_in = 1'b0;
    recv_msg(20, waited, bytes, ferr, sent_at);
    tests_run += 2;
    if (waited != 1) begin
      tests_failed++; $display("FAIL rst_after_latency: got %0d expected 1", waited);
    end
    if (ferr != 0 || sent_at != 300) begin
      tests_failed++; $display("FAIL rst_after_frame: got ferr=%0d len=%0d expected 0/300",
                               ferr, sent_at);
    end
    for (int j = 0; j < 3; j++) begin
      e = 8'hxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      tests_run++;
      if (bytes[8*j+:8] !== e) begin
        tests_failed++; $display("FAIL rst_after_byte%0d: got %h expected %h",
                                 j, bytes[8*j+:8], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_note_off();
    test_patterns();
    test_back_to_back();
    test_full_pop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
